multicycle_ctrl: RTL and testbench

Control FSM for the multicycle RV32I datapath. It is the producer side of the ALU control interface: it decodes the latched instruction, sequences fetch/decode/execute/memory/writeback, and drives alu_ctrl (encoding below) plus all datapath selects and write enables. It consumes the ALU zero flag for branch resolution and a memory ready handshake for fetch, load and store.

---
 rtl/multicycle_ctrl.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for the multicycle RV32I datapath.
//
// Sequences fetch / decode / execute / memory / writeback for the latched
// instruction and drives the ALU operation code, every datapath select and
// every write enable. All outputs are Moore-style decodes of the state
// register, except where a handshake input is passed straight through
// (mem_ready in FETCH/MEMWRITE, zero in BRANCH).
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset; also masks write enables,
//              illegal and instr_done while low
//   instr      instruction register (op [6:0], funct3 [14:12], f7b5 [30])
//   zero       ALU zero flag, used to resolve branches
//   mem_ready  memory access completed this cycle
//   alu_ctrl   ALU operation code
//   alu_src_a  00 PC, 01 oldPC, 10 rs1
//   alu_src_b  00 rs2, 01 imm, 10 constant 4
//   imm_src    000 I, 001 S, 010 B, 011 J, 100 U
//   result_src 00 aluout reg, 01 data reg, 10 ALU direct, 11 imm
//   adr_src    memory address: 0 PC, 1 result
//   pc_write, ir_write, mem_write, reg_write  write enables
//   illegal    one-cycle pulse for an unsupported instruction
//   instr_done one-cycle pulse on the last cycle of an instruction
module multicycle_ctrl #(
  parameter int RESET_STATE = 0,
  parameter int ALU_CTRL_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            imm_src,
  output logic [1:0]            result_src,
  output logic                  adr_src,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  illegal,
  output logic                  instr_done
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_AUIPC    = 4'd8,
    S_ALUWB    = 4'd9,
    S_LUI      = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_JALR2    = 4'd13,
    S_BRANCH   = 4'd14
  } state_t;

  localparam state_t RST_ST = state_t'(RESET_STATE[3:0]);

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(9);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t     state_q, state_d;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       f7b5;
  logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c;
  logic       illegal_c, done_c;
  logic       unused_instr_bits;

  assign op     = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7b5   = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // R/I-type operation; f7b5 selects SUB only for R-type, SRA for both.
  function automatic logic [ALU_CTRL_W-1:0] funct_alu(input logic [2:0] f3,
                                                      input logic       b5,
                                                      input logic       rtype);
    logic [ALU_CTRL_W-1:0] r;
    case (f3)
      3'b000:  r = (rtype && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = b5 ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // Comparison used to resolve a branch; reserved funct3 falls back to ADD.
  function automatic logic [ALU_CTRL_W-1:0] branch_alu(input logic [2:0] f3);
    logic [ALU_CTRL_W-1:0] r;
    case (f3[2:1])
      2'b00:   r = ALU_SUB;
      2'b10:   r = ALU_SLT;
      2'b11:   r = ALU_SLTU;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  // BEQ/BGE/BGEU take on zero; BNE/BLT/BLTU take on !zero (SLT result 1).
  function automatic logic branch_take(input logic [2:0] f3, input logic z);
    logic t;
    case (f3)
      3'b000, 3'b101, 3'b111: t = z;
      3'b001, 3'b100, 3'b110: t = !z;
      default:                t = 1'b0;
    endcase
    return t;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RST_ST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    alu_ctrl    = ALU_ADD;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 3'b000;
    result_src  = 2'b00;
    adr_src     = 1'b0;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    done_c      = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write_c = mem_ready;
        ir_write_c = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jump target computed early into the aluout register.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
            illegal_c = 1'b1;
            done_c    = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (op == OP_LOAD) begin
          imm_src = IMM_I;
          state_d = S_MEMREAD;
        end else begin
          imm_src = IMM_S;
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) begin
          done_c  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl  = funct_alu(funct3, f7b5, 1'b1);
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = IMM_I;
        alu_ctrl  = funct_alu(funct3, f7b5, 1'b0);
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_U;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_LUI: begin
        result_src  = 2'b11;
        imm_src     = IMM_U;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // PC <- target held in aluout; ALU forms oldPC+4 for the link.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = IMM_I;
        state_d   = S_JALR2;
      end
      S_JALR2: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_ctrl   = branch_alu(funct3);
        pc_write_c = branch_take(funct3, zero);
        illegal_c  = (funct3[2:1] == 2'b01);
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every side effect so an abandoned instruction writes nothing.
  assign pc_write   = pc_write_c  & rst_n;
  assign ir_write   = ir_write_c  & rst_n;
  assign mem_write  = mem_write_c & rst_n;
  assign reg_write  = reg_write_c & rst_n;
  assign illegal    = illegal_c   & rst_n;
  assign instr_done = done_c      & rst_n;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic [3:0]  alu_ctrl;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  imm_src;
  logic        adr_src, pc_write, ir_write, mem_write, reg_write, illegal, instr_done;

  multicycle_ctrl #(.RESET_STATE(0), .ALU_CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .result_src(result_src), .adr_src(adr_src),
    .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .illegal(illegal), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  // {alu[19:16], a[15:14], b[13:12], imm[11:9], res[8:7], adr[6], pcw, irw, mw, rw, ill, done}
  logic [19:0] dut_outs;
  assign dut_outs = {alu_ctrl, alu_src_a, alu_src_b, imm_src, result_src, adr_src,
                     pc_write, ir_write, mem_write, reg_write, illegal, instr_done};

  localparam logic [5:0] PCW = 6'b100000, IRW = 6'b010000, MW = 6'b001000;
  localparam logic [5:0] RW  = 6'b000100, ILL = 6'b000010, DN = 6'b000001;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
  localparam logic [3:0] SLT = 4'd5, SLL = 4'd6, SLTU = 4'd7, SRA = 4'd8, SRL = 4'd9;

  typedef struct packed {
    logic [19:0] outs;   // outputs when nothing depends on inputs
    logic        wait_rdy; // step repeats until mem_ready
    logic [19:0] rmask;  // bits that follow mem_ready
    logic [1:0]  br;     // 1: pc_write=zero, 2: pc_write=!zero
  } step_t;

  step_t mq[$];
  int errors = 0;
  int checks = 0;
  int last_mw, last_rw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pk(input logic [3:0] alu, input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] imm, input logic [1:0] res,
                                     input logic adr, input logic [5:0] en);
    return {alu, a, b, imm, res, adr, en};
  endfunction

  function automatic step_t st(input logic [19:0] o, input logic w, input logic [19:0] rm,
                               input logic [1:0] br);
    step_t s;
    s.outs = o; s.wait_rdy = w; s.rmask = rm; s.br = br;
    return s;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    logic [6:0] legal [9];
    legal = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input bit rtype);
    logic [3:0] tab [8];
    logic [3:0] r;
    tab = '{ADD, SLL, SLT, SLTU, XOR_, SRL, OR_, AND_};
    r = tab[f3];
    if (f3 == 3'd0 && rtype && f7) r = SUB;
    if (f3 == 3'd5 && f7) r = SRA;
    return r;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, as a list of steps.
  function automatic void build(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [1:0] br_tab [8];
    logic [19:0] aluwb;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[30];
    br_tab = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd2, 2'd1, 2'd2, 2'd1};
    aluwb = pk(ADD, 2'b00, 2'b00, 3'd0, 2'b00, 1'b0, RW | DN);
    mq.delete();
    mq.push_back(st(pk(ADD, 2'b00, 2'b10, 3'd0, 2'b10, 1'b0, 6'd0), 1'b1, {14'd0, PCW | IRW}, 2'd0));
    if (!is_legal(op)) begin
      mq.push_back(st(pk(ADD, 2'b01, 2'b01, 3'd2, 2'b00, 1'b0, ILL | DN), 1'b0, 20'd0, 2'd0));
      return;
    end
    mq.push_back(st(pk(ADD, 2'b01, 2'b01, (op == 7'h6F) ? 3'd3 : 3'd2, 2'b00, 1'b0, 6'd0), 1'b0, 20'd0, 2'd0));
    case (op)
      7'h03: begin
        mq.push_back(st(pk(ADD, 2'b10, 2'b01, 3'd0, 2'b00, 1'b0, 6'd0), 1'b0, 20'd0, 2'd0));
        mq.push_back(st(pk(ADD, 2'b00, 2'b00, 3'd0, 2'b00, 1'b1, 6'd0), 1'b1, 20'd0, 2'd0));
        mq.push_back(st(pk(ADD, 2'b00, 2'b00, 3'd0, 2'b01, 1'b0, RW | DN), 1'b0, 20'd0, 2'd0));
      end
      7'h23: begin
        mq.push_back(st(pk(ADD, 2'b10, 2'b01, 3'd1, 2'b00, 1'b0, 6'd0), 1'b0, 20'd0, 2'd0));
        mq.push_back(st(pk(ADD, 2'b00, 2'b00, 3'd0, 2'b00, 1'b1, MW), 1'b1, {14'd0, DN}, 2'd0));
      end
      7'h33: begin
        mq.push_back(st(pk(alu_ref(f3, f7, 1), 2'b10, 2'b00, 3'd0, 2'b00, 1'b0, 6'd0), 1'b0, 20'd0, 2'd0));
        mq.push_back(st(aluwb, 1'b0, 20'd0, 2'd0));
      end
      7'h13: begin
        mq.push_back(st(pk(alu_ref(f3, f7, 0), 2'b10, 2'b01, 3'd0, 2'b00, 1'b0, 6'd0), 1'b0, 20'd0, 2'd0));
        mq.push_back(st(aluwb, 1'b0, 20'd0, 2'd0));
      end
      7'h17: begin
        mq.push_back(st(pk(ADD, 2'b01, 2'b01, 3'd4, 2'b00, 1'b0, 6'd0), 1'b0, 20'd0, 2'd0));
        mq.push_back(st(aluwb, 1'b0, 20'd0, 2'd0));
      end
      7'h37: mq.push_back(st(pk(ADD, 2'b00, 2'b00, 3'd4, 2'b11, 1'b0, RW | DN), 1'b0, 20'd0, 2'd0));
      7'h6F: begin
        mq.push_back(st(pk(ADD, 2'b01, 2'b10, 3'd0, 2'b00, 1'b0, PCW), 1'b0, 20'd0, 2'd0));
        mq.push_back(st(aluwb, 1'b0, 20'd0, 2'd0));
      end
      7'h67: begin
        mq.push_back(st(pk(ADD, 2'b10, 2'b01, 3'd0, 2'b00, 1'b0, 6'd0), 1'b0, 20'd0, 2'd0));
        mq.push_back(st(pk(ADD, 2'b01, 2'b10, 3'd0, 2'b00, 1'b0, PCW), 1'b0, 20'd0, 2'd0));
        mq.push_back(st(aluwb, 1'b0, 20'd0, 2'd0));
      end
      default: begin // branch
        logic [3:0] a;
        logic [5:0] en;
        a  = (f3[2:1] == 2'b00) ? SUB : (f3[2:1] == 2'b10) ? SLT : (f3[2:1] == 2'b11) ? SLTU : ADD;
        en = (br_tab[f3] == 2'd0) ? (ILL | DN) : DN;
        mq.push_back(st(pk(a, 2'b10, 2'b00, 3'd0, 2'b00, 1'b0, en), 1'b0, 20'd0, br_tab[f3]));
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [6:0] op);
    case (op)
      7'h03, 7'h67:                return 5;
      7'h23, 7'h33, 7'h13, 7'h17, 7'h6F: return 4;
      7'h37, 7'h63:                return 3;
      default:                     return 2;
    endcase
  endfunction

  // zmode: 0/1 force zero, 2 random. fst/mst: not-ready cycles in fetch / memory wait.
  task automatic run_instr(input logic [31:0] ins, input int fst, input int mst, input int zmode);
    int idx, cyc, done_cyc, ndone, stall_left, exp_lat;
    logic [19:0] e;
    build(ins);
    idx = 0; cyc = 0; done_cyc = -1; ndone = 0; stall_left = fst;
    last_mw = 0; last_rw = 0;
    while (idx < mq.size() && cyc < 64) begin
      @(negedge clk);
      if (cyc == 0) instr = ins;
      if (mq[idx].wait_rdy) mem_ready = (stall_left > 0) ? 1'b0 : 1'b1;
      else                  mem_ready = 1'($urandom % 2);
      zero = (zmode == 2) ? 1'($urandom % 2) : zmode[0];
      #2;
      e = mq[idx].outs;
      if (mq[idx].wait_rdy && mem_ready) e = e | mq[idx].rmask;
      if (mq[idx].br == 2'd1) e[5] = zero;
      if (mq[idx].br == 2'd2) e[5] = !zero;
      check($sformatf("outs_%08h_c%0d", ins, cyc), {12'd0, dut_outs}, {12'd0, e});
      if (instr_done) begin ndone++; done_cyc = cyc + 1; end
      last_mw += int'(mem_write);
      last_rw += int'(reg_write);
      cyc++;
      if (mq[idx].wait_rdy) begin
        if (mem_ready) begin idx++; stall_left = mst; end
        else stall_left--;
      end else idx++;
    end
    exp_lat = lat_of(ins[6:0]) + fst + ((ins[6:0] == 7'h03 || ins[6:0] == 7'h23) ? mst : 0);
    check($sformatf("done_cnt_%08h", ins), ndone, 1);
    check($sformatf("latency_%08h", ins), done_cyc, exp_lat);
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'h002081B3; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check("reset_fetch", {12'd0, dut_outs}, {12'd0, pk(ADD, 2'b00, 2'b10, 3'd0, 2'b10, 1'b0, 6'd0)});

    // reset while decoding an illegal opcode masks illegal/instr_done
    @(posedge clk); #1 rst_n = 1'b1; instr = 32'h0000007F;
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check("reset_decode_mask", {12'd0, dut_outs}, {12'd0, pk(ADD, 2'b01, 2'b01, 3'd2, 2'b00, 1'b0, 6'd0)});
    @(posedge clk); #1 rst_n = 1'b1;

    // directed cases
    run_instr(32'h002081B3, 0, 0, 2);              // add
    run_instr(32'h402081B3, 0, 0, 2);              // sub
    run_instr(32'h4020D1B3, 0, 0, 2);              // sra
    run_instr(32'h0020B193, 0, 0, 2);              // sltiu
    run_instr(32'h00209463, 0, 0, 1);              // bne, zero=1
    run_instr(32'h00209463, 0, 0, 0);              // bne, zero=0
    run_instr(32'h0020C463, 0, 0, 0);              // blt, zero=0
    run_instr(32'h0000A183, 3, 3, 2);              // lw with stalls
    check("lw_reg_write_cycles", last_rw, 1);
    run_instr(32'h0030A023, 0, 2, 2);              // sw with stalls
    check("sw_mem_write_cycles", last_mw, 3);
    run_instr(32'h0000007F, 0, 0, 2);              // illegal opcode
    run_instr(32'h0020A463, 0, 0, 2);              // reserved branch funct3
    run_instr(32'h123451B7, 0, 0, 2);              // lui
    run_instr(32'h00001197, 1, 0, 2);              // auipc
    run_instr(32'h008000EF, 0, 0, 2);              // jal
    run_instr(32'h000080E7, 2, 0, 2);              // jalr

    // reset during EXECR abandons the add with no writeback
    @(negedge clk); instr = 32'h002081B3; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("reset_execr", {12'd0, dut_outs}, {12'd0, pk(ADD, 2'b10, 2'b00, 3'd0, 2'b00, 1'b0, 6'd0)});
    @(posedge clk); #1 rst_n = 1'b1;
    run_instr(32'h0020F1B3, 0, 0, 2);              // and, from FETCH after reset

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ins;
      logic [6:0]  ops [9];
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      ins = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        ins[6:0] = 7'($urandom);
        for (int k = 0; k < 8 && is_legal(ins[6:0]); k++) ins[6:0] = 7'($urandom);
        if (is_legal(ins[6:0])) ins[6:0] = 7'h7F;
      end else begin
        ins[6:0] = ops[$urandom_range(0, 8)];
      end
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
